// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite register file slave.
package axi4lite_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // Write-path channel state; the AW/W hold flags and BVALID are decoded from it.
  typedef enum logic [1:0] {
    WR_IDLE   = 2'b00,
    WR_AW_HELD = 2'b01,
    WR_W_HELD = 2'b10,
    WR_RESP   = 2'b11
  } wr_state_e;

endpackage

// File: rtl/axi4lite_regbank.sv
// Register storage: one byte-enabled write port, one combinational read port.
module axi4lite_regbank
  import axi4lite_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [STRB_WIDTH-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Byte-lane update of the addressed register; whole bank clears on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_be_i[b]) begin
          regs_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // Read port sees the pre-edge contents, which gives read-before-write on collisions.
  assign rd_data_o = regs_q[rd_idx_i];

endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave front end: independent read/write channels over a register bank.
//
// Write FSM
//   state      | meaning
//   WR_IDLE    | nothing held, AW and W both ready
//   WR_AW_HELD | address captured, waiting for write data
//   WR_W_HELD  | data captured, waiting for write address
//   WR_RESP    | write committed, BVALID asserted until BREADY
module axi4lite_slave_regfile
  import axi4lite_pkg::*;
#(
  parameter int              ADDR_WIDTH = 8,
  parameter int              NUM_REGS   = 16,
  parameter logic [31:0]     ID_VALUE   = 32'hA4C0_0001
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W      = ADDR_WIDTH - 2;
  localparam int BANK_IDX_W = $clog2(NUM_REGS);

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  wr_state_e             wr_state_q, wr_state_d;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  resp_t                 bresp_q;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;

  logic                  aw_held, w_held;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_ok, bank_we;
  logic [DATA_WIDTH-1:0] bank_rd_data;
  logic [DATA_WIDTH-1:0] rdata_d;
  resp_t                 rresp_d;

  // Byte-offset bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign aw_held = (wr_state_q == WR_AW_HELD);
  assign w_held  = (wr_state_q == WR_W_HELD);
  assign BVALID  = (wr_state_q == WR_RESP);

  // Readies come from registered state only, never from the same-channel VALID.
  assign AWREADY = !aw_held && !BVALID;
  assign WREADY  = !w_held && !BVALID;
  assign ARREADY = !rvalid_q;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  // A held channel wins over the live bus, since its ready is low anyway.
  assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held ? wdata_q : WDATA;
  assign wr_strb = w_held ? wstrb_q : WSTRB;
  assign wr_ok   = idx_in_range(wr_idx) && (wr_idx != '0);
  assign bank_we = commit && wr_ok;

  assign rd_idx  = ARADDR[ADDR_WIDTH-1:2];

  // Write channel state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  // Write channel next state: collect AW and W in any order, then respond.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (commit) begin
          wr_state_d = WR_RESP;
        end else if (aw_hs) begin
          wr_state_d = WR_AW_HELD;
        end else if (w_hs) begin
          wr_state_d = WR_W_HELD;
        end
      end
      WR_AW_HELD: if (w_hs)   wr_state_d = WR_RESP;
      WR_W_HELD:  if (aw_hs)  wr_state_d = WR_RESP;
      WR_RESP:    if (BREADY) wr_state_d = WR_IDLE;
      default:    wr_state_d = WR_IDLE;
    endcase
  end

  // Holding registers for whichever write channel arrives first, plus BRESP.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      if (aw_hs) aw_idx_q <= AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (commit) bresp_q <= wr_ok ? OKAY : SLVERR;
    end
  end

  assign BRESP = bresp_q;

  // Read decode: ID at index 0, bank contents in range, zero with SLVERR beyond.
  always_comb begin
    rdata_d = '0;
    rresp_d = SLVERR;
    if (rd_idx == '0) begin
      rdata_d = ID_VALUE;
      rresp_d = OKAY;
    end else if (idx_in_range(rd_idx)) begin
      rdata_d = bank_rd_data;
      rresp_d = OKAY;
    end
  end

  // Read response register, held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  axi4lite_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (BANK_IDX_W)
  ) u_regbank (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .wr_en_i   (bank_we),
    .wr_idx_i  (wr_idx[BANK_IDX_W-1:0]),
    .wr_be_i   (wr_strb),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx[BANK_IDX_W-1:0]),
    .rd_data_o (bank_rd_data)
  );

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile with hand-computed expectations.
module tb_axi4lite_slave_regfile;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [7:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int n_tests = 0;
  int n_fail  = 0;

  axi4lite_slave_regfile #(
    .ADDR_WIDTH (8),
    .NUM_REGS   (16),
    .ID_VALUE   (32'hA4C0_0001)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done;
    int   n;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY)   w_done  = 1'b1;
      @(posedge ACLK); #1;
      if (aw_done) AWVALID = 1'b0;
      if (w_done)  WVALID  = 1'b0;
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("wr_hs_done", {30'd0, aw_done, w_done}, 32'd3);
    check_eq("b_latency", {31'd0, BVALID}, 32'd1);
    resp = BRESP;
    if (BREADY) begin
      @(posedge ACLK); #1;
      check_eq("b_clear", {31'd0, BVALID}, 32'd0);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic done;
    int   n;
    ARADDR = addr; ARVALID = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      done = ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    ARVALID = 1'b0;
    check_eq("ar_hs_done", {31'd0, done}, 32'd1);
    check_eq("r_latency", {31'd0, RVALID}, 32'd1);
    data = RDATA;
    resp = RRESP;
    if (RREADY) begin
      @(posedge ACLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;

    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    #12;
    check_eq("rst_awready", {31'd0, AWREADY}, 32'd1);
    check_eq("rst_wready",  {31'd0, WREADY},  32'd1);
    check_eq("rst_arready", {31'd0, ARREADY}, 32'd1);
    check_eq("rst_bvalid",  {31'd0, BVALID},  32'd0);
    check_eq("rst_rvalid",  {31'd0, RVALID},  32'd0);
    check_eq("rst_bresp",   {30'd0, BRESP},   32'd0);
    check_eq("rst_rresp",   {30'd0, RRESP},   32'd0);
    check_eq("rst_rdata",   RDATA,            32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Basic write then read
    do_write(8'h04, 32'hDEAD_BEEF, 4'hF, resp);
    check_eq("basic_bresp", {30'd0, resp}, 32'd0);
    do_read(8'h04, data, resp);
    check_eq("basic_rdata", data, 32'hDEAD_BEEF);
    check_eq("basic_rresp", {30'd0, resp}, 32'd0);

    // Zero strobe leaves contents alone; single high byte lane
    do_write(8'h04, 32'hFFFF_FFFF, 4'h0, resp);
    check_eq("strb0_bresp", {30'd0, resp}, 32'd0);
    do_read(8'h04, data, resp);
    check_eq("strb0_rdata", data, 32'hDEAD_BEEF);
    do_write(8'h04, 32'h1200_0000, 4'b1000, resp);
    do_read(8'h04, data, resp);
    check_eq("strb_hi_rdata", data, 32'h12AD_BEEF);

    // W first, AW held back three cycles
    WDATA = 32'h1122_3344; WSTRB = 4'b0101; WVALID = 1'b1;
    check_eq("ooo_wready_pre", {31'd0, WREADY}, 32'd1);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("ooo_wready_held", {31'd0, WREADY}, 32'd0);
      check_eq("ooo_awready", {31'd0, AWREADY}, 32'd1);
      check_eq("ooo_bvalid_early", {31'd0, BVALID}, 32'd0);
      @(posedge ACLK); #1;
    end
    AWADDR = 8'h08; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check_eq("ooo_bvalid", {31'd0, BVALID}, 32'd1);
    check_eq("ooo_bresp", {30'd0, BRESP}, 32'd0);
    @(posedge ACLK); #1;
    do_read(8'h08, data, resp);
    check_eq("ooo_partial_rdata", data, 32'h0022_0044);

    // Error responses
    do_write(8'h00, 32'h0BAD_0BAD, 4'hF, resp);
    check_eq("id_wr_bresp", {30'd0, resp}, 32'd2);
    do_read(8'h00, data, resp);
    check_eq("id_rdata", data, 32'hA4C0_0001);
    check_eq("id_rresp", {30'd0, resp}, 32'd0);
    do_write(8'h40, 32'h1234_5678, 4'hF, resp);
    check_eq("oor_wr_bresp", {30'd0, resp}, 32'd2);
    do_read(8'h40, data, resp);
    check_eq("oor_rdata", data, 32'd0);
    check_eq("oor_rresp", {30'd0, resp}, 32'd2);
    do_read(8'h3C, data, resp);
    check_eq("last_reg_rresp", {30'd0, resp}, 32'd0);

    // Write response backpressure with a read going through meanwhile
    BREADY = 1'b0;
    do_write(8'h10, 32'hCAFE_F00D, 4'hF, resp);
    check_eq("bp_bresp", {30'd0, resp}, 32'd0);
    do_read(8'h04, data, resp);
    check_eq("bp_read_rdata", data, 32'h12AD_BEEF);
    check_eq("bp_read_rresp", {30'd0, resp}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_bvalid", {31'd0, BVALID}, 32'd1);
      check_eq("bp_bresp_stable", {30'd0, BRESP}, 32'd0);
      check_eq("bp_awready", {31'd0, AWREADY}, 32'd0);
      check_eq("bp_wready", {31'd0, WREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    check_eq("bp_release", {31'd0, BVALID}, 32'd0);
    do_read(8'h10, data, resp);
    check_eq("bp_rdata", data, 32'hCAFE_F00D);

    // Read and write hit the same register on the same edge
    AWADDR = 8'h0C; WDATA = 32'h0000_0055; WSTRB = 4'hF; ARADDR = 8'h0C;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check_eq("col_bvalid", {31'd0, BVALID}, 32'd1);
    check_eq("col_rvalid", {31'd0, RVALID}, 32'd1);
    check_eq("col_rdata_old", RDATA, 32'd0);
    @(posedge ACLK); #1;
    do_read(8'h0C, data, resp);
    check_eq("col_rdata_new", data, 32'h0000_0055);

    // Asynchronous reset with both responses pending
    BREADY = 1'b0; RREADY = 1'b0;
    do_write(8'h14, 32'h0000_0077, 4'hF, resp);
    do_read(8'h04, data, resp);
    check_eq("pre_rst_rvalid", {31'd0, RVALID}, 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check_eq("arst_bvalid",  {31'd0, BVALID},  32'd0);
    check_eq("arst_rvalid",  {31'd0, RVALID},  32'd0);
    check_eq("arst_rdata",   RDATA,            32'd0);
    check_eq("arst_bresp",   {30'd0, BRESP},   32'd0);
    check_eq("arst_awready", {31'd0, AWREADY}, 32'd1);
    check_eq("arst_wready",  {31'd0, WREADY},  32'd1);
    check_eq("arst_arready", {31'd0, ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    ARESETN = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    do_read(8'h04, data, resp);
    check_eq("arst_reg4", data, 32'd0);
    do_read(8'h0C, data, resp);
    check_eq("arst_reg3", data, 32'd0);
    do_read(8'h10, data, resp);
    check_eq("arst_reg4_cafe", data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regfile.md
# axi4lite_slave_regfile

- AXI4-Lite responder with a 32-bit register file.
- It is the DUT-side counterpart of the AXI4-Lite verification agent: it accepts the agent's READ, WRITE and concurrent BOTH traffic and returns OKAY/SLVERR responses.
- Read and write channels run independently, and the write path accepts AW and W in either order.
- Storage is a small register bank with byte-strobe writes and a read-only ID register at index 0.

## Interface
Parameters:
- ADDR_WIDTH, 8: AWADDR/ARADDR width; at least log2(NUM_REGS)+2.
- NUM_REGS, 16: number of 32-bit registers; must be 2 or more.
- ID_VALUE, 32'hA4C0_0001: constant read from register 0.

Ports:
- ACLK, input, 1: single clock; all logic is rising-edge.
- ARESETN, input, 1: reset, asynchronous, active-low.
- AWADDR, input, ADDR_WIDTH, plus AWVALID (input, 1) and AWREADY (output, 1): write-address channel.
- WDATA, input, 32; WSTRB, input, 4; WVALID (input, 1) and WREADY (output, 1): write-data channel.
- BRESP, output, 2, plus BVALID (output, 1) and BREADY (input, 1): write-response channel.
- ARADDR, input, ADDR_WIDTH, plus ARVALID (input, 1) and ARREADY (output, 1): read-address channel.
- RDATA, output, 32; RRESP, output, 2; RVALID (output, 1) and RREADY (input, 1): read-data channel.

## Operation
Address decode:
- The register index is addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored.
- An index of NUM_REGS or above is out of range.

Write path (two hold flags, aw_held and w_held, plus BVALID):
- AWREADY = !aw_held && !BVALID.
- WREADY = !w_held && !BVALID.
- Each channel is captured into its own holding register on its handshake.
- Commit happens on the edge at which both address and data are available. That is either held or handshaking on that edge; AW and W handshaking on the same edge is allowed.
- On commit, each byte b with WSTRB[b]=1 is updated. Hold flags clear, BVALID is set, and BRESP is set as below.
- BRESP = SLVERR (2'b10) for index 0 (read-only) or out of range; the write is discarded.
- BRESP = OKAY (2'b00) otherwise, including WSTRB=0 (no bytes change).
- BVALID holds, with BRESP stable, until the edge where BREADY=1, then clears.
- At most one write is outstanding.

Read path:
- ARREADY = !RVALID.
- On an AR handshake, RDATA and RRESP are registered and RVALID is set.
- RDATA = ID_VALUE for index 0, the register contents for a valid index, and 0 for out of range.
- RRESP = OKAY for index 0 and valid indices, SLVERR for out of range.
- RVALID, RDATA and RRESP hold stable until the edge where RREADY=1.

Collision rule: if a read samples and a write commits to the same register on the same edge, the read returns the pre-write value.

## Timing
Reset values (ARESETN=0, asynchronous):
- BVALID, RVALID, aw_held and w_held = 0.
- BRESP, RRESP and RDATA = 0.
- All registers = 0.
- AWREADY, WREADY and ARREADY = 1 (they are derived from the cleared state).
- Reset mid-transaction abandons all pending and held transfers with no response.

Latencies and backpressure:
- Write response: BVALID rises one cycle after the completing handshake edge.
- Read response: RVALID rises one cycle after the AR handshake edge.
- With BREADY and RREADY tied high, throughput is one write per 2 cycles and one read per 2 cycles.
- Ready is not combinationally dependent on the same-channel VALID.
- BREADY/RREADY held low stall the channel indefinitely; the other direction is unaffected.

## Structure
- A shared package axi4lite_pkg holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - DATA_WIDTH=32 and STRB_WIDTH=4 constants.
- The top-level handles the channel FSMs and decode. Storage goes in one sub-module, axi4lite_regbank, which has:
  - one write port: index, 4-bit byte enable, data;
  - one asynchronous read port;
  - asynchronous reset to 0.

## Test plan
- Basic write then read: AW(0x04) and W(0xDEADBEEF, WSTRB=4'hF) in the same cycle with BREADY=1 → BVALID one cycle later with OKAY. Then AR(0x04) → RDATA=0xDEADBEEF with OKAY.
- Out-of-order channels: W alone first (AW held back 3 cycles, WREADY low afterwards), then AW(0x08) → commit on the AW edge.
  - Partial strobe: WSTRB=4'b0101 with 0x11223344 over a register holding 0 → read back 0x00220044.
- Error responses:
  - Write to 0x00 → SLVERR, and a read of 0x00 still returns 0xA4C00001 with OKAY.
  - Write/read to 0x40 (index 16) → SLVERR/SLVERR, RDATA=0.
- Backpressure: BREADY=0 for 5 cycles → BVALID and BRESP stable, AWREADY and WREADY stay 0. Meanwhile a read completes normally.
- Collision and reset:
  - Write 0x55 to 0x0C while AR(0x0C) handshakes on the same edge → read returns the old value 0, and a subsequent read returns 0x55.
  - ARESETN pulsed low while BVALID=1 → all outputs return to reset values immediately (asynchronously), and registers read back 0.
